oc_bank_arbiter: RTL

Register-file bank arbiter sitting directly upstream of the operand collector units. It accepts operand read requests from 8 operand slots (4 collector units × 2 source operands) and performs round-robin arbitration per register bank, with writeback taking priority. It returns bank data tagged with the destination slot on the per-bank `bk_N_data`/`ocid`/`bz`/`vld` buses that the collector units snoop.

---
 rtl/oc_pkg.sv | 20 ++
 rtl/oc_bank_arbiter_if.sv | 44 ++++
 rtl/oc_rr_arbiter.sv | 38 +++
 rtl/oc_bank_arbiter.sv | 113 +++++++++++
 4 files changed

// File: rtl/oc_pkg.sv
// Shared constants and helpers for the operand-collector bank arbiter.
package oc_pkg;

  localparam int unsigned NUM_SLOTS  = 8;
  localparam int unsigned NUM_BANKS  = 4;
  localparam int unsigned SLOT_W     = 3;
  localparam int unsigned REG_ID_W   = 5;
  localparam int unsigned BANK_ROW_W = 3;
  localparam int unsigned WARP_W     = 3;
  localparam int unsigned BANK_SEL_W = 2;
  localparam int unsigned LANES      = 8;
  localparam int unsigned DATA_W     = 256;
  localparam int unsigned RF_ADDR_W  = WARP_W + BANK_ROW_W;
  localparam int unsigned CNT_W      = 16;

  function automatic logic [BANK_SEL_W-1:0] bank_sel(logic [REG_ID_W-1:0] reg_id);
    return reg_id[4:3];
  endfunction

endpackage

// File: rtl/oc_bank_arbiter_if.sv
// Request, writeback, register-file and bank-return bundle of the bank arbiter.
interface oc_bank_arbiter_if;
  import oc_pkg::*;

  logic [NUM_SLOTS-1:0]           req_vld;
  logic [NUM_SLOTS*REG_ID_W-1:0]  req_reg_id;
  logic [NUM_SLOTS*WARP_W-1:0]    req_warp;
  logic [NUM_SLOTS-1:0]           req_ack;
  logic                           wb_vld;
  logic [REG_ID_W-1:0]            wb_reg_id;
  logic [WARP_W-1:0]              wb_warp;
  logic [DATA_W-1:0]              wb_data;
  logic [LANES-1:0]               wb_mask;
  logic [NUM_BANKS-1:0]           rf_rd_en;
  logic [NUM_BANKS*RF_ADDR_W-1:0] rf_rd_addr;
  logic [NUM_BANKS*DATA_W-1:0]    rf_rd_data;
  logic [NUM_BANKS-1:0]           rf_wr_en;
  logic [RF_ADDR_W-1:0]           rf_wr_addr;
  logic [DATA_W-1:0]              rf_wr_data;
  logic [LANES-1:0]               rf_wr_mask;
  logic [DATA_W-1:0]              bk_0_data, bk_1_data, bk_2_data, bk_3_data;
  logic [SLOT_W-1:0]              bk_0_ocid, bk_1_ocid, bk_2_ocid, bk_3_ocid;
  logic                           bk_0_bz, bk_1_bz, bk_2_bz, bk_3_bz;
  logic                           bk_0_vld, bk_1_vld, bk_2_vld, bk_3_vld;
  logic [NUM_BANKS*CNT_W-1:0]     perf_conflict_cnt;

  modport master (
    output req_vld, req_reg_id, req_warp, wb_vld, wb_reg_id, wb_warp, wb_data, wb_mask,
           rf_rd_data,
    input  req_ack, rf_rd_en, rf_rd_addr, rf_wr_en, rf_wr_addr, rf_wr_data, rf_wr_mask,
           bk_0_data, bk_1_data, bk_2_data, bk_3_data, bk_0_ocid, bk_1_ocid, bk_2_ocid,
           bk_3_ocid, bk_0_bz, bk_1_bz, bk_2_bz, bk_3_bz, bk_0_vld, bk_1_vld, bk_2_vld,
           bk_3_vld, perf_conflict_cnt
  );

  modport slave (
    input  req_vld, req_reg_id, req_warp, wb_vld, wb_reg_id, wb_warp, wb_data, wb_mask,
           rf_rd_data,
    output req_ack, rf_rd_en, rf_rd_addr, rf_wr_en, rf_wr_addr, rf_wr_data, rf_wr_mask,
           bk_0_data, bk_1_data, bk_2_data, bk_3_data, bk_0_ocid, bk_1_ocid, bk_2_ocid,
           bk_3_ocid, bk_0_bz, bk_1_bz, bk_2_bz, bk_3_bz, bk_0_vld, bk_1_vld, bk_2_vld,
           bk_3_vld, perf_conflict_cnt
  );
endinterface

// File: rtl/oc_rr_arbiter.sv
// 8-way round-robin arbiter; pointer moves past the winner, grant gated by en_i.
module oc_rr_arbiter
  import oc_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [NUM_SLOTS-1:0] req_i,
  input  logic                 en_i,
  output logic [NUM_SLOTS-1:0] gnt_o,
  output logic                 gnt_vld_o,
  output logic [SLOT_W-1:0]    gnt_idx_o
);

  logic [SLOT_W-1:0] ptr_q, ptr_d;
  logic [SLOT_W-1:0] idx;

  always_comb begin
    gnt_vld_o = 1'b0;
    gnt_idx_o = ptr_q;
    gnt_o     = '0;
    idx       = ptr_q;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      idx = ptr_q + SLOT_W'(i);
      if (en_i && !gnt_vld_o && req_i[idx]) begin
        gnt_vld_o = 1'b1;
        gnt_idx_o = idx;
      end
    end
    if (gnt_vld_o) gnt_o[gnt_idx_o] = 1'b1;
    ptr_d = gnt_vld_o ? gnt_idx_o + SLOT_W'(1) : ptr_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end

endmodule

// File: rtl/oc_bank_arbiter.sv
// Per-bank round-robin read arbiter with writeback priority and registered return tags.
// Optional per-bank conflict counters are built when OC_ARB_STATS_EN is defined.
module oc_bank_arbiter
  import oc_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  oc_bank_arbiter_if.slave bus
);

  logic [NUM_BANKS-1:0][NUM_SLOTS-1:0] bank_req, bank_gnt;
  logic [NUM_BANKS-1:0][SLOT_W-1:0]    gnt_idx;
  logic [NUM_BANKS-1:0]                gnt_vld, wb_hit;
  logic [NUM_BANKS-1:0]                ret_vld_q, ret_vld_d, bz_q, bz_d;
  logic [NUM_BANKS-1:0][SLOT_W-1:0]    ret_ocid_q, ret_ocid_d;

  always_comb begin
    bank_req = '0;
    wb_hit   = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      wb_hit[b] = bus.wb_vld && (bank_sel(bus.wb_reg_id) == BANK_SEL_W'(b));
      for (int s = 0; s < NUM_SLOTS; s++) begin
        bank_req[b][s] = bus.req_vld[s] &&
                         (bank_sel(bus.req_reg_id[s*REG_ID_W +: REG_ID_W]) == BANK_SEL_W'(b));
      end
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    oc_rr_arbiter u_rr (
      .clk_i     (clk),
      .rst_ni    (rst),
      .req_i     (bank_req[b]),
      .en_i      (!wb_hit[b]),
      .gnt_o     (bank_gnt[b]),
      .gnt_vld_o (gnt_vld[b]),
      .gnt_idx_o (gnt_idx[b])
    );
  end

  always_comb begin
    bus.req_ack    = '0;
    bus.rf_rd_addr = '0;
    ret_vld_d      = gnt_vld;
    bz_d           = wb_hit;
    ret_ocid_d     = ret_ocid_q;
    for (int b = 0; b < NUM_BANKS; b++) begin
      bus.req_ack |= bank_gnt[b];
      bus.rf_rd_addr[b*RF_ADDR_W +: RF_ADDR_W] =
        {bus.req_warp[gnt_idx[b]*WARP_W +: WARP_W],
         bus.req_reg_id[gnt_idx[b]*REG_ID_W +: BANK_ROW_W]};
      if (gnt_vld[b]) ret_ocid_d[b] = gnt_idx[b];
    end
  end

  assign bus.rf_rd_en   = gnt_vld;
  assign bus.rf_wr_en   = wb_hit;
  assign bus.rf_wr_addr = {bus.wb_warp, bus.wb_reg_id[BANK_ROW_W-1:0]};
  assign bus.rf_wr_data = bus.wb_data;
  assign bus.rf_wr_mask = bus.wb_mask;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ret_vld_q  <= '0;
      bz_q       <= '0;
      ret_ocid_q <= '0;
    end else begin
      ret_vld_q  <= ret_vld_d;
      bz_q       <= bz_d;
      ret_ocid_q <= ret_ocid_d;
    end
  end

  // Return data is the SRAM output itself; only the tag and flags are registered here.
  assign bus.bk_0_data = bus.rf_rd_data[0*DATA_W +: DATA_W];
  assign bus.bk_1_data = bus.rf_rd_data[1*DATA_W +: DATA_W];
  assign bus.bk_2_data = bus.rf_rd_data[2*DATA_W +: DATA_W];
  assign bus.bk_3_data = bus.rf_rd_data[3*DATA_W +: DATA_W];
  assign bus.bk_0_ocid = ret_ocid_q[0];
  assign bus.bk_1_ocid = ret_ocid_q[1];
  assign bus.bk_2_ocid = ret_ocid_q[2];
  assign bus.bk_3_ocid = ret_ocid_q[3];
  assign bus.bk_0_bz   = bz_q[0];
  assign bus.bk_1_bz   = bz_q[1];
  assign bus.bk_2_bz   = bz_q[2];
  assign bus.bk_3_bz   = bz_q[3];
  assign bus.bk_0_vld  = ret_vld_q[0];
  assign bus.bk_1_vld  = ret_vld_q[1];
  assign bus.bk_2_vld  = ret_vld_q[2];
  assign bus.bk_3_vld  = ret_vld_q[3];

`ifdef OC_ARB_STATS_EN
  logic [NUM_BANKS-1:0][CNT_W-1:0] cnt_q, cnt_d;

  // A cycle counts when any requester of the bank is left without an ack.
  always_comb begin
    cnt_d = cnt_q;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (|(bank_req[b] & ~bank_gnt[b]) && (cnt_q[b] != '1)) cnt_d[b] = cnt_q[b] + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign bus.perf_conflict_cnt = cnt_q;
`else
  assign bus.perf_conflict_cnt = '0;
`endif

endmodule
